// File: rtl/ape_enc_pkg.sv
// Shared widths, FSM state type and the unkeyed round function for the instruction encryptor.
package ape_enc_pkg;

  localparam int unsigned WORD_W  = 34;
  localparam int unsigned KEY_W   = 64;
  localparam int unsigned TAG_W   = 16;
  localparam int unsigned STATE_W = 50;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StEmit,
    StPerm,
    StTag
  } enc_state_e;

  function automatic logic [STATE_W-1:0] rotl(input logic [STATE_W-1:0] x, input int unsigned n);
    return (x << n) | (x >> (STATE_W - n));
  endfunction

  // Nonlinear mixing step; the round key is added separately by the caller.
  function automatic logic [STATE_W-1:0] rnd(input logic [STATE_W-1:0] x);
    return x ^ rotl(x, 1) ^ (rotl(x, 7) & rotl(x, 13));
  endfunction

endpackage

// File: rtl/ape_perm_round.sv
// One keyed permutation round: rnd(S) xor a round key chosen by round parity.
module ape_perm_round
  import ape_enc_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [3:0]         round_i,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] rk;

  assign rk      = round_i[0] ? key_i[63:14] : key_i[49:0];
  assign state_o = rnd(state_i) ^ rk;

endmodule

// File: rtl/ape_inst_encryptor.sv
// Duplex-style instruction stream encryptor: absorbs 34-bit words, emits ciphertext, then a tag.
module ape_inst_encryptor
  import ape_enc_pkg::*;
#(
  parameter int unsigned ROUNDS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [15:0]       vc_i,
  input  logic              start_i,
  input  logic              pt_valid_i,
  output logic              pt_ready_o,
  input  logic [WORD_W-1:0] pt_data_i,
  input  logic              pt_last_i,
  output logic              ct_valid_o,
  input  logic              ct_ready_i,
  output logic [WORD_W-1:0] ct_data_o,
  output logic              tag_valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o
);

  enc_state_e         state_q;
  logic [KEY_W-1:0]   key_q;
  logic [STATE_W-1:0] s_q;
  logic [3:0]         round_q;
  logic               last_q;
  logic [WORD_W-1:0]  ct_q;
  logic [TAG_W-1:0]   tag_q;
  logic [STATE_W-1:0] perm_out;
  logic [WORD_W-1:0]  absorbed;

  ape_perm_round u_perm_round (
    .state_i (s_q),
    .key_i   (key_q),
    .round_i (round_q),
    .state_o (perm_out)
  );

  assign absorbed = s_q[WORD_W-1:0] ^ pt_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      key_q   <= '0;
      s_q     <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
      ct_q    <= '0;
      tag_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            key_q   <= key_i;
            s_q     <= {vc_i, {WORD_W{1'b0}}} ^ key_i[STATE_W-1:0];
            state_q <= StAccept;
          end
        end
        StAccept: begin
          if (pt_valid_i) begin
            s_q[WORD_W-1:0] <= absorbed;
            ct_q            <= absorbed;
            last_q          <= pt_last_i;
            state_q         <= StEmit;
          end
        end
        StEmit: begin
          if (ct_ready_i) begin
            round_q <= '0;
            state_q <= StPerm;
          end
        end
        StPerm: begin
          s_q     <= perm_out;
          round_q <= round_q + 4'd1;
          if (round_q == 4'(ROUNDS - 1)) begin
            if (last_q) begin
              // Tag is taken from the final round output so it is valid during TAG.
              tag_q   <= perm_out[TAG_W-1:0] ^ key_q[TAG_W-1:0];
              state_q <= StTag;
            end else begin
              state_q <= StAccept;
            end
          end
        end
        StTag: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pt_ready_o  = (state_q == StAccept);
  assign ct_valid_o  = (state_q == StEmit);
  assign ct_data_o   = ct_q;
  assign tag_valid_o = (state_q == StTag);
  assign tag_o       = tag_q;
  assign busy_o      = (state_q != StIdle);

endmodule
